// File: rtl/cursor_overlay_if.sv
// Pixel-stream side of the cursor overlay: raster position and frame pulse in,
// overlay colour and coverage flag out.
interface cursor_overlay_if;
  // Free-running stream with no valid/ready pair: one raster position is
  // presented every clk_in cycle and is always accepted. The result for that
  // position appears exactly two cycles later. There is no backpressure.
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        new_frame_in;
  logic [7:0]  red_out;
  logic [7:0]  green_out;
  logic [7:0]  blue_out;
  logic        in_sprite;

  modport master (
    output hcount_in, vcount_in, new_frame_in,
    input  red_out, green_out, blue_out, in_sprite
  );

  modport slave (
    input  hcount_in, vcount_in, new_frame_in,
    output red_out, green_out, blue_out, in_sprite
  );
endinterface

// File: rtl/cursor_overlay.sv
// Multi-cursor sprite generator. Per-frame shadowed cursor state, signed hit
// tests, blink gating, and a two-stage pipeline ending in a registered RGB.
module cursor_overlay #(
  parameter int NUM_CURSORS  = 2,
  parameter int SCALE        = 2,
  parameter int BOX_HALF     = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  cursor_overlay_if.slave          vid,
  input  logic [NUM_CURSORS*10-1:0] x_in,
  input  logic [NUM_CURSORS*9-1:0]  y_in,
  input  logic [NUM_CURSORS*3-1:0]  stroke_width,
  input  logic [NUM_CURSORS*2-1:0]  cursor_mode,
  input  logic [NUM_CURSORS*4-1:0]  cursor_color,
  input  logic [NUM_CURSORS-1:0]    blink_en
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [12:0] BOXW = 13'(BOX_HALF);

  logic [9:0] sh_x     [NUM_CURSORS];
  logic [8:0] sh_y     [NUM_CURSORS];
  logic [2:0] sh_sw    [NUM_CURSORS];
  logic [1:0] sh_mode  [NUM_CURSORS];
  logic [3:0] sh_color [NUM_CURSORS];
  logic [NUM_CURSORS-1:0] sh_blink;

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  // Shadows and blink state move together on the frame pulse, so the first
  // pixel sampled after the pulse sees a consistent new cursor set.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CURSORS; i++) begin
        sh_x[i]     <= '0;
        sh_y[i]     <= '0;
        sh_sw[i]    <= '0;
        sh_mode[i]  <= '0;
        sh_color[i] <= '0;
      end
      sh_blink    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (vid.new_frame_in) begin
      for (int i = 0; i < NUM_CURSORS; i++) begin
        sh_x[i]     <= x_in[10*i +: 10];
        sh_y[i]     <= y_in[9*i +: 9];
        sh_sw[i]    <= stroke_width[3*i +: 3];
        sh_mode[i]  <= cursor_mode[2*i +: 2];
        sh_color[i] <= cursor_color[4*i +: 4];
      end
      sh_blink <= blink_en;
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic [NUM_CURSORS-1:0] hit_c;

  // Distances are taken one bit wider than the 12-bit centre so the
  // subtraction itself cannot wrap; a cursor at 0 never hits the far edge.
  for (genvar g = 0; g < NUM_CURSORS; g++) begin : g_cur
    logic signed [11:0] cx, cy;
    logic signed [12:0] dx, dy;
    logic        [12:0] ax, ay, ext;
    logic               box_hit, cross_hit, outline_hit, shape_hit;

    assign cx  = $signed(12'(32'(sh_x[g]) * SCALE));
    assign cy  = $signed(12'(32'(sh_y[g]) * SCALE));
    assign dx  = $signed({2'b00, vid.hcount_in}) - $signed({cx[11], cx});
    assign dy  = $signed({3'b000, vid.vcount_in}) - $signed({cy[11], cy});
    assign ax  = dx[12] ? 13'(-dx) : 13'(dx);
    assign ay  = dy[12] ? 13'(-dy) : 13'(dy);
    assign ext = 13'((32'(sh_sw[g]) + 32'd1) * SCALE);

    assign box_hit     = (ax <= BOXW) && (ay <= BOXW);
    assign cross_hit   = ((dx == 13'sd0) && (ay <= ext)) || ((dy == 13'sd0) && (ax <= ext));
    assign outline_hit = box_hit && ((ax == BOXW) || (ay == BOXW));
    assign shape_hit   = (sh_mode[g] == 2'd1) ? cross_hit :
                         (sh_mode[g] == 2'd2) ? box_hit :
                         (sh_mode[g] == 2'd3) ? outline_hit : 1'b0;
    assign hit_c[g]    = shape_hit && !(sh_blink[g] && blink_phase);
  end

  logic [NUM_CURSORS-1:0] s1_hit;
  logic [3:0]             s1_pal [NUM_CURSORS];
  logic                   s1_valid;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_hit   <= '0;
      s1_valid <= 1'b0;
      for (int i = 0; i < NUM_CURSORS; i++) s1_pal[i] <= '0;
    end else begin
      s1_hit   <= hit_c;
      s1_valid <= 1'b1;
      for (int i = 0; i < NUM_CURSORS; i++) s1_pal[i] <= sh_color[i];
    end
  end

  logic       sel_hit;
  logic [3:0] sel_pal;
  logic [7:0] pal_r, pal_g, pal_b;

  function automatic logic [7:0] chan(input logic bit_set, input logic bright);
    return bit_set ? (bright ? 8'hFF : 8'h80) : 8'h00;
  endfunction

  // Walk from the highest index down so the lowest hitting cursor wins.
  always_comb begin
    sel_hit = 1'b0;
    sel_pal = '0;
    for (int i = NUM_CURSORS - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        sel_hit = 1'b1;
        sel_pal = s1_pal[i];
      end
    end
    if (sel_pal[2:0] == 3'd0) begin
      pal_r = 8'h80;
      pal_g = 8'h80;
      pal_b = 8'h80;
    end else begin
      pal_r = chan(sel_pal[0], sel_pal[3]);
      pal_g = chan(sel_pal[1], sel_pal[3]);
      pal_b = chan(sel_pal[2], sel_pal[3]);
    end
  end

  logic [7:0] red_q, green_q, blue_q;
  logic       sprite_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      sprite_q <= 1'b0;
    end else if (s1_valid && sel_hit) begin
      red_q    <= pal_r;
      green_q  <= pal_g;
      blue_q   <= pal_b;
      sprite_q <= 1'b1;
    end else begin
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      sprite_q <= 1'b0;
    end
  end

  assign vid.red_out   = red_q;
  assign vid.green_out = green_q;
  assign vid.blue_out  = blue_q;
  assign vid.in_sprite = sprite_q;

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay: stimulus pushes expected {in_sprite,R,G,B}
// into a queue, a negedge monitor pops and compares two cycles later.
module tb_cursor_overlay;

  localparam logic [24:0] OFF   = 25'h0;
  localparam logic [24:0] GREY  = {1'b1, 8'h80, 8'h80, 8'h80};
  localparam logic [24:0] WHITE = {1'b1, 8'hFF, 8'hFF, 8'hFF};

  // clock / reset
  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b1;
  always #5 clk_in = ~clk_in;

  cursor_overlay_if vif ();

  logic [19:0] x_in         = '0;
  logic [17:0] y_in         = '0;
  logic [5:0]  stroke_width = '0;
  logic [3:0]  cursor_mode  = '0;
  logic [7:0]  cursor_color = '0;
  logic [1:0]  blink_en     = '0;

  cursor_overlay #(
    .NUM_CURSORS(2), .SCALE(2), .BOX_HALF(5), .BLINK_FRAMES(2)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .vid(vif),
    .x_in(x_in), .y_in(y_in), .stroke_width(stroke_width),
    .cursor_mode(cursor_mode), .cursor_color(cursor_color), .blink_en(blink_en)
  );

  // scoreboard
  logic [24:0] exp_q[$];
  string       name_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic        issued = 1'b0;
  logic        iss_d1 = 1'b0;
  logic        iss_d2 = 1'b0;
  logic [24:0] dut_out;

  assign dut_out = {vif.in_sprite, vif.red_out, vif.green_out, vif.blue_out};

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk_in) begin
    iss_d1 <= issued;
    iss_d2 <= iss_d1;
  end

  always @(negedge clk_in) begin
    if (iss_d2) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_output: got %h with empty queue", dut_out);
      end else begin
        check(name_q.pop_front(), dut_out, exp_q.pop_front());
      end
    end
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic set_cur(input int i, input logic [9:0] x, input logic [8:0] y,
                         input logic [1:0] mode, input logic [2:0] sw,
                         input logic [3:0] col, input logic bl);
    x_in[10*i +: 10]        = x;
    y_in[9*i +: 9]          = y;
    cursor_mode[2*i +: 2]   = mode;
    stroke_width[3*i +: 3]  = sw;
    cursor_color[4*i +: 4]  = col;
    blink_en[i]             = bl;
  endtask

  task automatic pix(input logic [10:0] h, input logic [9:0] v,
                     input logic [24:0] exp, input string name);
    vif.hcount_in = h;
    vif.vcount_in = v;
    issued = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk_in); #1;
  endtask

  task automatic idle();
    issued = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic pulse(input int n);
    issued = 1'b0;
    vif.new_frame_in = 1'b1;
    repeat (n) @(posedge clk_in);
    #1;
    vif.new_frame_in = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    issued = 1'b0;
    cyc = 0;
    while ((exp_q.size() != 0 || iss_d1 || iss_d2) && cyc < 50) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
  endtask

  logic [8:1] blink_vis;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.hcount_in    = '0;
    vif.vcount_in    = '0;
    vif.new_frame_in = 1'b0;
    #2 rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 check("reset_outputs", dut_out, OFF);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // single crosshair: centre (200,100), half-extent (1+1)*2 = 4
    set_cur(0, 10'd100, 9'd50, 2'd1, 3'd1, 4'd0, 1'b0);
    pix(11'd200, 10'd100, OFF, "xhair_before_frame");
    pulse(1);
    pix(11'd200, 10'd96,  GREY, "xhair_top");
    pix(11'd200, 10'd104, GREY, "xhair_bottom");
    pix(11'd196, 10'd100, GREY, "xhair_left");
    pix(11'd204, 10'd100, GREY, "xhair_right");
    pix(11'd200, 10'd100, GREY, "xhair_centre");
    pix(11'd205, 10'd100, OFF,  "xhair_past_right");
    pix(11'd200, 10'd95,  OFF,  "xhair_past_top");
    pix(11'd201, 10'd101, OFF,  "xhair_diagonal");
    drain();

    // filled box at origin, colour 1111 = white; must not wrap to h=2043..2047
    set_cur(0, 10'd0, 9'd0, 2'd2, 3'd0, 4'b1111, 1'b0);
    pulse(1);
    pix(11'd0,    10'd0, WHITE, "edge_origin");
    pix(11'd5,    10'd5, WHITE, "edge_corner");
    pix(11'd5,    10'd0, WHITE, "edge_right");
    pix(11'd6,    10'd0, OFF,   "edge_h6");
    pix(11'd0,    10'd6, OFF,   "edge_v6");
    pix(11'd2043, 10'd0, OFF,   "edge_nowrap_2043");
    pix(11'd2047, 10'd0, OFF,   "edge_nowrap_2047");
    pix(11'd2047, 10'd3, OFF,   "edge_nowrap_2047_3");
    pix(11'd0,  10'd1023, OFF,  "edge_nowrap_v1023");
    drain();

    // outlined box at (200,100), colour 0100 = blue 80
    set_cur(0, 10'd100, 9'd50, 2'd3, 3'd0, 4'b0100, 1'b0);
    pulse(1);
    pix(11'd195, 10'd100, {1'b1, 8'h00, 8'h00, 8'h80}, "outline_left");
    pix(11'd203, 10'd95,  {1'b1, 8'h00, 8'h00, 8'h80}, "outline_top");
    pix(11'd200, 10'd100, OFF, "outline_interior");
    pix(11'd206, 10'd100, OFF, "outline_outside");
    drain();

    // frame latching: x moves 100 -> 300 mid-frame
    set_cur(0, 10'd100, 9'd50, 2'd1, 3'd1, 4'd0, 1'b0);
    pulse(1);
    pix(11'd200, 10'd100, GREY, "latch_old_pos");
    x_in[9:0] = 10'd300;
    pix(11'd200, 10'd100, GREY, "latch_still_old");
    pix(11'd600, 10'd100, OFF,  "latch_new_not_yet");
    // pixel sampled in the pulse cycle still sees the old shadow
    vif.hcount_in = 11'd600;
    vif.vcount_in = 10'd100;
    issued = 1'b1;
    exp_q.push_back(OFF);
    name_q.push_back("latch_pulse_cycle");
    vif.new_frame_in = 1'b1;
    @(posedge clk_in); #1;
    vif.new_frame_in = 1'b0;
    pix(11'd600, 10'd100, GREY, "latch_moved");
    pix(11'd200, 10'd100, OFF,  "latch_old_gone");
    drain();

    // priority: cursor0 box at (200,100) colour 1001, cursor1 box at (208,100) colour 0010
    set_cur(0, 10'd100, 9'd50, 2'd2, 3'd0, 4'b1001, 1'b0);
    set_cur(1, 10'd104, 9'd50, 2'd2, 3'd0, 4'b0010, 1'b0);
    pulse(1);
    pix(11'd204, 10'd100, {1'b1, 8'hFF, 8'h00, 8'h00}, "prio_overlap");
    pix(11'd212, 10'd100, {1'b1, 8'h00, 8'h80, 8'h00}, "prio_c1_only");
    pix(11'd196, 10'd100, {1'b1, 8'hFF, 8'h00, 8'h00}, "prio_c0_only");
    pix(11'd214, 10'd100, OFF, "prio_outside");
    drain();
    set_cur(1, 10'd0, 9'd0, 2'd0, 3'd0, 4'd0, 1'b0);

    // reset asserted while a cursor pixel is being shown
    set_cur(0, 10'd100, 9'd50, 2'd2, 3'd0, 4'b1111, 1'b0);
    pulse(1);
    pix(11'd200, 10'd100, WHITE, "rst_pre_hit");
    drain();
    check("rst_sprite_before", dut_out, WHITE);
    #2 rst_n_in = 1'b0;
    #1 check("rst_async_clear", dut_out, OFF);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    pix(11'd200, 10'd100, OFF, "rst_no_draw_after");
    pix(11'd200, 10'd100, OFF, "rst_no_draw_after2");
    pulse(1);
    pix(11'd200, 10'd100, WHITE, "rst_reload");
    drain();

    // blink, BLINK_FRAMES=2; frame N = state after N pulses (frame 0 precedes the first)
    do_reset();
    blink_vis = 8'b1001_1001;
    set_cur(0, 10'd100, 9'd50, 2'd2, 3'd0, 4'd0,    1'b1);
    set_cur(1, 10'd300, 9'd50, 2'd2, 3'd0, 4'b1111, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      pulse(1);
      pix(11'd200, 10'd100, blink_vis[k] ? GREY : OFF, $sformatf("blink_frame%0d", k));
      pix(11'd600, 10'd100, WHITE, $sformatf("steady_frame%0d", k));
      idle();
    end
    // two back-to-back pulse cycles count as frames 7 and 8
    pulse(2);
    pix(11'd200, 10'd100, blink_vis[8] ? GREY : OFF, "blink_frame8_consecutive");
    pix(11'd600, 10'd100, WHITE, "steady_frame8");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
